tile_load_ctrl: RTL and testbench
=================================

# tile_load_ctrl

Sequences the loading of one compute tile into the on-chip input memory, kernel memory and overlap cache from the host a/b streams. Accepts paired address/data words on a valid/ready handshake, decodes the target region, drives registered write strobes, and counts words per region. When every region is full, it raises `data_ready` to the compute controller and holds it until `fsm_done` ends the tile. It sits between the testbench/host I/O and the top-level memories, replacing host-driven write enables.

## Interface
- `IO_DATA_WIDTH`, 16: width of a/b words and write bus.
- `INPUT_WORDS`, 16384: words the input memory needs per tile (≥1).
- `KERNEL_WORDS`, 512: words the kernel memory needs per tile (≥1).
- `OVERLAP_WORDS`, 256: words the overlap cache needs per tile (≥1).
- `clk` in 1: clock, rising edge.
- `arst_n_in` in 1: asynchronous reset, active low.
- `start` in 1: begin loading a tile; sampled only in IDLE.
- `a_input` in IO_DATA_WIDTH: target address; [15:14] selects the region: 0x/01 = input, 10 = kernel, 11 = overlap.
- `a_valid` in 1; `a_ready` out 1.
- `b_input` in IO_DATA_WIDTH: data word.
- `b_valid` in 1; `b_ready` out 1.
- `int_mem_we` out 1: write strobe for input/kernel memories.
- `overlap_cache_we` out 1: write strobe for the overlap cache.
- `wr_addr` out IO_DATA_WIDTH: registered copy of the accepted `a_input`.
- `wr_data` out IO_DATA_WIDTH: registered copy of the accepted `b_input`.
- `data_ready` out 1: tile complete; level signal.
- `fsm_done` in 1: compute finished with the tile; single-cycle pulse.
- `busy` out 1: state ≠ IDLE.
- `overflow` out 1: sticky; a word arrived for a region already full.

## Operation
- States: IDLE, LOAD, FLUSH, READY.
- IDLE → LOAD on `start`. Region counters clear on entry to LOAD, as does `overflow`.
- Ready signals:
  - `a_ready` = LOAD & `b_valid`.
  - `b_ready` = LOAD & `a_valid`.
  - Both are 0 in every other state. Ready may depend on valid; valid must not depend on ready.
- Fire condition: LOAD & `a_valid` & `b_valid`. A fire transfers a and b together; one valid alone never transfers.
- On fire, the region is decoded from `a_input[15:14]`:
  - Input or kernel region → `int_mem_we` = 1 next cycle. The top level splits input/kernel on `wr_addr[15]`.
  - Overlap region → `overlap_cache_we` = 1 next cycle and `int_mem_we` = 0.
  - `wr_addr`/`wr_data` load in both cases.
- Counters:
  - Each region counter increments on a fire to its region and saturates at its target.
  - A fire to a full region is still written but not counted, and sets `overflow`.
  - Duplicate addresses are counted; address uniqueness is the host's responsibility.
- LOAD → FLUSH in the cycle after the fire that makes all three counters equal their targets, so that ready deasserts there.
- FLUSH lasts exactly one cycle so that the last write lands before compute reads; then FLUSH → READY.
- READY:
  - `data_ready` = 1 and the write strobes are 0.
  - READY → IDLE on `fsm_done`; `data_ready` drops the same edge.
- Ignored events:
  - `fsm_done` outside READY.
  - `start` outside IDLE.
  - Simultaneous `start` + `fsm_done` in READY: `fsm_done` is taken, and `start` must be reasserted in IDLE.
- Reset (at any time, including mid-LOAD): all outputs 0, state IDLE, counters 0. Partially written memory contents are not erased.

## Timing
- Write latency: fire at edge k → strobe, `wr_addr` and `wr_data` valid during cycle k+1, for exactly one cycle per fire.
- Throughput: one word per cycle when both valids are held.
- Final fire at edge k:
  - Last strobe during k+1, state FLUSH in k+1.
  - READY and `data_ready` = 1 from k+2.
  - Ready signals are 0 from k+1.
- `busy` is registered from state; `data_ready` is a registered decode.
- Counter width: $clog2(TARGET+1) each.

## Structure
- Package `tile_load_pkg`:
  - state enum `tl_state_t` {IDLE, LOAD, FLUSH, READY}.
  - region enum `tl_region_t` {REG_INPUT, REG_KERNEL, REG_OVERLAP}.
  - localparams for the region-bit positions [15:14].
- Sub-module `sat_word_counter` (params `TARGET`):
  - Ports: `clk`, `arst_n_in`, `clr`, `inc`, `full` out, `count` out.
  - Instantiated three times.
- Remainder: FSM, decode, output registers, `overflow` flag; about 200 lines total.

## Test plan
All scenarios use INPUT_WORDS = 4, KERNEL_WORDS = 2, OVERLAP_WORDS = 1.
- Basic load:
  - Stimulus: `start`, then 7 back-to-back fires: 4 input (0x0000–0x0003), 2 kernel (0x8000–0x8001), 1 overlap (0xC000).
  - Response: 6 `int_mem_we` pulses, 1 `overlap_cache_we` pulse, `wr_data` matches `b_input` one cycle late; `data_ready` = 1 two cycles after the 7th fire.
- Handshake gating:
  - Stimulus: `a_valid` = 1 with `b_valid` = 0 for 5 cycles.
  - Response: `a_ready` = 0, no strobe, counters unchanged; raising `b_valid` gives a single fire.
- Overflow:
  - Stimulus: 3 kernel words sent during LOAD.
  - Response: third word strobed, `overflow` = 1, kernel count stays 2, still waits for remaining input/overlap words.
- Completion handshake:
  - Stimulus: `fsm_done` pulse during LOAD → ignored; pulse in READY.
  - Response: IDLE, `data_ready` = 0 next cycle, `busy` = 0; a new `start` clears counters and `overflow`.
- Reset mid-load:
  - Stimulus: `arst_n_in` low after 3 fires.
  - Response: all outputs 0 immediately; after release plus `start`, 7 fresh words are required before `data_ready`.
- Ignored start:
  - Stimulus: `start` held high throughout LOAD/READY.
  - Response: no counter clear, state sequence unchanged.

Source files
------------

// File: rtl/tile_load_pkg.sv
// Shared types and helpers for the tile load controller.
package tile_load_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, READY} tl_state_t;
  typedef enum logic [1:0] {REG_INPUT, REG_KERNEL, REG_OVERLAP} tl_region_t;

  localparam int REGION_MSB = 15;
  localparam int REGION_LSB = 14;

  // 0x and 01 both land in the input memory; it owns the lower half of the map.
  function automatic tl_region_t decode_region(input logic [1:0] sel);
    case (sel)
      2'b10:   decode_region = REG_KERNEL;
      2'b11:   decode_region = REG_OVERLAP;
      default: decode_region = REG_INPUT;
    endcase
  endfunction

endpackage

// File: rtl/tile_load_ctrl_counter.sv
// Per-region word counter that stops at its target and reports when full.
module sat_word_counter #(
  parameter int TARGET = 1,
  parameter int CW     = $clog2(TARGET + 1)
) (
  input  logic          clk,
  input  logic          arst_n_in,
  input  logic          clr,
  input  logic          inc,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)                           count_q <= '0;
    else if (clr)                             count_q <= '0;
    else if (inc && (count_q != CW'(TARGET))) count_q <= count_q + CW'(1);
  end

  assign full  = (count_q == CW'(TARGET));
  assign count = count_q;

endmodule

// File: rtl/tile_load_ctrl.sv
// Loads one compute tile from the host a/b streams into input, kernel and
// overlap memories, then holds data_ready until compute signals fsm_done.
module tile_load_ctrl
  import tile_load_pkg::*;
#(
  parameter int IO_DATA_WIDTH = 16,
  parameter int INPUT_WORDS   = 16384,
  parameter int KERNEL_WORDS  = 512,
  parameter int OVERLAP_WORDS = 256
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     start,
  input  logic [IO_DATA_WIDTH-1:0] a_input,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [IO_DATA_WIDTH-1:0] b_input,
  input  logic                     b_valid,
  output logic                     b_ready,
  output logic                     int_mem_we,
  output logic                     overlap_cache_we,
  output logic [IO_DATA_WIDTH-1:0] wr_addr,
  output logic [IO_DATA_WIDTH-1:0] wr_data,
  output logic                     data_ready,
  input  logic                     fsm_done,
  output logic                     busy,
  output logic                     overflow
);

  localparam int IW = $clog2(INPUT_WORDS + 1);
  localparam int KW = $clog2(KERNEL_WORDS + 1);
  localparam int OW = $clog2(OVERLAP_WORDS + 1);

  tl_state_t  state_q, state_d;
  tl_region_t region;
  logic       fire, clr;
  logic       in_full, kn_full, ov_full;
  logic       in_inc, kn_inc, ov_inc;
  logic       in_last, kn_last, ov_last, region_full;
  logic [IW-1:0] in_cnt;
  logic [KW-1:0] kn_cnt;
  logic [OW-1:0] ov_cnt;

  logic                     int_we_q, ov_we_q, busy_q, data_ready_q, overflow_q;
  logic [IO_DATA_WIDTH-1:0] wr_addr_q, wr_data_q;

  assign a_ready = (state_q == LOAD) & b_valid;
  assign b_ready = (state_q == LOAD) & a_valid;
  assign fire    = (state_q == LOAD) & a_valid & b_valid;
  assign clr     = (state_q == IDLE) & start;
  assign region  = decode_region(a_input[REGION_MSB:REGION_LSB]);

  assign in_inc = fire & (region == REG_INPUT)   & ~in_full;
  assign kn_inc = fire & (region == REG_KERNEL)  & ~kn_full;
  assign ov_inc = fire & (region == REG_OVERLAP) & ~ov_full;

  sat_word_counter #(.TARGET(INPUT_WORDS)) u_in_cnt (
    .clk(clk), .arst_n_in(arst_n_in), .clr(clr), .inc(in_inc), .full(in_full), .count(in_cnt));
  sat_word_counter #(.TARGET(KERNEL_WORDS)) u_kn_cnt (
    .clk(clk), .arst_n_in(arst_n_in), .clr(clr), .inc(kn_inc), .full(kn_full), .count(kn_cnt));
  sat_word_counter #(.TARGET(OVERLAP_WORDS)) u_ov_cnt (
    .clk(clk), .arst_n_in(arst_n_in), .clr(clr), .inc(ov_inc), .full(ov_full), .count(ov_cnt));

  // Look one fire ahead so ready drops in the cycle right after the final word.
  assign in_last = in_full | (in_inc & (in_cnt == IW'(INPUT_WORDS - 1)));
  assign kn_last = kn_full | (kn_inc & (kn_cnt == KW'(KERNEL_WORDS - 1)));
  assign ov_last = ov_full | (ov_inc & (ov_cnt == OW'(OVERLAP_WORDS - 1)));

  always_comb begin
    region_full = 1'b0;
    case (region)
      REG_KERNEL:  region_full = kn_full;
      REG_OVERLAP: region_full = ov_full;
      default:     region_full = in_full;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (fire && in_last && kn_last && ov_last) state_d = FLUSH;
      FLUSH:   state_d = READY;
      READY:   if (fsm_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      data_ready_q <= 1'b0;
      int_we_q     <= 1'b0;
      ov_we_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != IDLE);
      data_ready_q <= (state_d == READY);
      int_we_q     <= fire & (region != REG_OVERLAP);
      ov_we_q      <= fire & (region == REG_OVERLAP);
      if (fire) begin
        wr_addr_q <= a_input;
        wr_data_q <= b_input;
      end
      // Words to a full region are still written, only flagged.
      if (clr)                     overflow_q <= 1'b0;
      else if (fire && region_full) overflow_q <= 1'b1;
    end
  end

  assign int_mem_we       = int_we_q;
  assign overlap_cache_we = ov_we_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;
  assign data_ready       = data_ready_q;
  assign busy             = busy_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_tile_load_ctrl.sv
// Directed bench for tile_load_ctrl with a small tile (4 input, 2 kernel, 1 overlap).
module tb_tile_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, a_valid = 1'b0, b_valid = 1'b0, fsm_done = 1'b0;
  logic [15:0] a_input = '0, b_input = '0;
  logic        a_ready, b_ready, int_mem_we, overlap_cache_we, data_ready, busy, overflow;
  logic [15:0] wr_addr, wr_data;
  logic [6:0]  flags;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tile_load_ctrl #(
    .IO_DATA_WIDTH(16), .INPUT_WORDS(4), .KERNEL_WORDS(2), .OVERLAP_WORDS(1)
  ) dut (
    .clk(clk), .arst_n_in(rst_n), .start(start),
    .a_input(a_input), .a_valid(a_valid), .a_ready(a_ready),
    .b_input(b_input), .b_valid(b_valid), .b_ready(b_ready),
    .int_mem_we(int_mem_we), .overlap_cache_we(overlap_cache_we),
    .wr_addr(wr_addr), .wr_data(wr_data), .data_ready(data_ready),
    .fsm_done(fsm_done), .busy(busy), .overflow(overflow)
  );

  // {a_ready, b_ready, int_we, ov_we, data_ready, busy, overflow}
  assign flags = {a_ready, b_ready, int_mem_we, overlap_cache_we, data_ready, busy, overflow};

  typedef struct {
    logic        st, av, bv, done;
    logic [15:0] a, b;
    logic [6:0]  ef;
    logic [15:0] ea, ed;
  } vec_t;

  vec_t tv[$];

  function automatic void v(input logic st, av, bv, done, input logic [15:0] a, b,
                            input logic [6:0] ef, input logic [15:0] ea, ed);
    vec_t r;
    r.st = st; r.av = av; r.bv = bv; r.done = done; r.a = a; r.b = b;
    r.ef = ef; r.ea = ea; r.ed = ed;
    tv.push_back(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [15:0] fresh_a [6] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h8000, 16'h8001};

  initial begin
    int n;
    //   st av bv dn  a        b          flags       wr_addr   wr_data
    // basic load, ignored start in FLUSH/READY, start+done together in READY
    v(0, 0, 0, 0, 16'h0000, 16'h0000, 7'b0000000, 16'h0000, 16'h0000);
    v(1, 0, 0, 0, 16'h0000, 16'h0000, 7'b0000000, 16'h0000, 16'h0000);
    v(0, 1, 1, 0, 16'h0000, 16'h1111, 7'b1100010, 16'h0000, 16'h0000);
    v(0, 1, 1, 0, 16'h0001, 16'h2222, 7'b1110010, 16'h0000, 16'h1111);
    v(0, 1, 1, 0, 16'h0002, 16'h3333, 7'b1110010, 16'h0001, 16'h2222);
    v(0, 1, 1, 0, 16'h0003, 16'h4444, 7'b1110010, 16'h0002, 16'h3333);
    v(0, 1, 1, 0, 16'h8000, 16'h5555, 7'b1110010, 16'h0003, 16'h4444);
    v(0, 1, 1, 0, 16'h8001, 16'h6666, 7'b1110010, 16'h8000, 16'h5555);
    v(0, 1, 1, 0, 16'hC000, 16'h7777, 7'b1110010, 16'h8001, 16'h6666);
    v(1, 1, 1, 0, 16'h0004, 16'h9999, 7'b0001010, 16'hC000, 16'h7777);
    v(1, 1, 1, 0, 16'h0004, 16'h9999, 7'b0000110, 16'hC000, 16'h7777);
    v(1, 0, 0, 1, 16'h0000, 16'h0000, 7'b0000110, 16'hC000, 16'h7777);
    v(0, 0, 0, 0, 16'h0000, 16'h0000, 7'b0000000, 16'hC000, 16'h7777);
    v(0, 0, 0, 0, 16'h0000, 16'h0000, 7'b0000000, 16'hC000, 16'h7777);
    // handshake gating with fsm_done and start ignored during LOAD
    v(1, 0, 0, 0, 16'h0000, 16'h0000, 7'b0000000, 16'hC000, 16'h7777);
    v(0, 1, 0, 1, 16'h0000, 16'h0AAA, 7'b0100010, 16'hC000, 16'h7777);
    v(1, 1, 0, 0, 16'h0000, 16'h0AAA, 7'b0100010, 16'hC000, 16'h7777);
    v(1, 1, 0, 0, 16'h0000, 16'h0AAA, 7'b0100010, 16'hC000, 16'h7777);
    v(1, 1, 0, 0, 16'h0000, 16'h0AAA, 7'b0100010, 16'hC000, 16'h7777);
    v(1, 1, 0, 0, 16'h0000, 16'h0AAA, 7'b0100010, 16'hC000, 16'h7777);
    v(0, 1, 1, 0, 16'h0000, 16'h0AAA, 7'b1100010, 16'hC000, 16'h7777);
    v(0, 0, 1, 0, 16'h0000, 16'h0BBB, 7'b1010010, 16'h0000, 16'h0AAA);
    v(0, 0, 0, 0, 16'h0000, 16'h0000, 7'b0000010, 16'h0000, 16'h0AAA);
    // overflow on a third kernel word, then finish input and overlap
    v(0, 1, 1, 0, 16'h8000, 16'h0C01, 7'b1100010, 16'h0000, 16'h0AAA);
    v(0, 1, 1, 0, 16'h8001, 16'h0C02, 7'b1110010, 16'h8000, 16'h0C01);
    v(0, 1, 1, 0, 16'h8002, 16'h0C03, 7'b1110010, 16'h8001, 16'h0C02);
    v(0, 1, 1, 0, 16'h0001, 16'h0D01, 7'b1110011, 16'h8002, 16'h0C03);
    v(0, 1, 1, 0, 16'h0002, 16'h0D02, 7'b1110011, 16'h0001, 16'h0D01);
    v(0, 1, 1, 0, 16'h0003, 16'h0D03, 7'b1110011, 16'h0002, 16'h0D02);
    v(0, 0, 0, 0, 16'h0000, 16'h0000, 7'b0010011, 16'h0003, 16'h0D03);
    v(0, 1, 1, 0, 16'hC001, 16'h0E01, 7'b1100011, 16'h0003, 16'h0D03);
    v(0, 0, 0, 0, 16'h0000, 16'h0000, 7'b0001011, 16'hC001, 16'h0E01);
    v(0, 0, 0, 0, 16'h0000, 16'h0000, 7'b0000111, 16'hC001, 16'h0E01);
    v(0, 0, 0, 1, 16'h0000, 16'h0000, 7'b0000111, 16'hC001, 16'h0E01);
    v(0, 0, 0, 0, 16'h0000, 16'h0000, 7'b0000001, 16'hC001, 16'h0E01);
    v(1, 0, 0, 0, 16'h0000, 16'h0000, 7'b0000001, 16'hC001, 16'h0E01);
    v(0, 0, 0, 0, 16'h0000, 16'h0000, 7'b0000010, 16'hC001, 16'h0E01);

    #2;
    chk("reset flags", 32'(flags), 32'h0);
    chk("reset wr_addr", 32'(wr_addr), 32'h0);
    chk("reset wr_data", 32'(wr_data), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      start = tv[i].st; a_valid = tv[i].av; b_valid = tv[i].bv; fsm_done = tv[i].done;
      a_input = tv[i].a; b_input = tv[i].b;
      @(negedge clk);
      chk($sformatf("row%0d flags", i),   32'(flags),   32'(tv[i].ef));
      chk($sformatf("row%0d wr_addr", i), 32'(wr_addr), 32'(tv[i].ea));
      chk($sformatf("row%0d wr_data", i), 32'(wr_data), 32'(tv[i].ed));
      @(posedge clk); #1;
    end

    // reset mid-load after three fires
    start = 0; fsm_done = 0; a_valid = 1; b_valid = 1;
    a_input = 16'h0000; b_input = 16'h2001; @(posedge clk); #1;
    a_input = 16'h0001; b_input = 16'h2002; @(posedge clk); #1;
    a_input = 16'h4000; b_input = 16'h2003; @(posedge clk); #1;
    chk("pre-reset int_we", 32'(int_mem_we), 32'h1);
    chk("pre-reset wr_addr", 32'(wr_addr), 32'h4000);
    rst_n = 1'b0; #1;
    chk("mid-load reset flags", 32'(flags), 32'h0);
    chk("mid-load reset wr_addr", 32'(wr_addr), 32'h0);
    chk("mid-load reset wr_data", 32'(wr_data), 32'h0);
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0; rst_n = 1'b1; start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("reload busy", 32'(busy), 32'h1);
    for (int i = 0; i < 6; i++) begin
      a_valid = 1; b_valid = 1; a_input = fresh_a[i]; b_input = 16'h3000 + 16'(i);
      @(posedge clk); #1;
    end
    a_valid = 0; b_valid = 0;
    repeat (3) @(posedge clk); #1;
    chk("six words not ready", 32'({busy, data_ready, overflow}), 32'b100);
    a_valid = 1; b_valid = 1; a_input = 16'hC000; b_input = 16'h3006;
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    chk("last word overlap strobe", 32'({int_mem_we, overlap_cache_we}), 32'b01);
    n = 1;
    while (!data_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("data_ready latency", 32'(n), 32'd2);
    fsm_done = 1; @(posedge clk); #1; fsm_done = 0;
    chk("done to idle", 32'({busy, data_ready}), 32'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
